fpu_mul_arbiter: RTL and testbench

FPU_MUL_ARBITER -- requirements
Module: fpu_mul_arbiter

---
 rtl/fpu_pkg.sv | 29 ++
 rtl/fpu_mul_tag_pipe.sv | 34 +++
 rtl/fpu_mul_arbiter.sv | 160 ++++++++++++++++
 tb/tb_fpu_mul_arbiter.sv | 298 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpu_pkg.sv
// Shared types for the FP multiplier arbiter slice.
// Holds the FSM state enum, flag vector and in-flight tag layout.
package fpu_pkg;

    localparam int MUL_LAT_DEF = 3;
    localparam int W_DEF       = 32;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } fsm_state_t;

    typedef struct packed {
        logic ovf;
        logic unf;
        logic zero;
    } mul_flags_t;

    typedef struct packed {
        logic valid;
        logic id;
    } mul_tag_t;

    function automatic logic [1:0] id_onehot(input logic id);
        return id ? 2'b10 : 2'b01;
    endfunction

endpackage

// File: rtl/fpu_mul_tag_pipe.sv
// Shift pipe of {valid, requester id} that tracks each issued multiply
// until its result is due back from the fixed-latency multiplier.
module fpu_mul_tag_pipe
    import fpu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF
) (
    input  logic CLK,
    input  logic RST,
    input  logic in_valid,
    input  logic in_id,
    output logic out_valid,
    output logic out_id
);

    mul_tag_t stage [MUL_LAT];

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int i = 0; i < MUL_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= '{valid: in_valid, id: in_id};
            for (int i = 1; i < MUL_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign out_valid = stage[MUL_LAT-1].valid;
    assign out_id    = stage[MUL_LAT-1].id;

endmodule

// File: rtl/fpu_mul_arbiter.sv
// Two-requester round-robin front end for a shared pipelined FP multiplier,
// with result routing, flush/drain control and sticky protocol error.
module fpu_mul_arbiter
    import fpu_pkg::*;
#(
    parameter int MUL_LAT = MUL_LAT_DEF,
    parameter int W       = W_DEF
) (
    input  logic         CLK,
    input  logic         RST,
    input  logic [1:0]   req_valid,
    output logic [1:0]   req_ready,
    input  logic [W-1:0] req_a0,
    input  logic [W-1:0] req_b0,
    input  logic [W-1:0] req_a1,
    input  logic [W-1:0] req_b1,
    output logic         mul_valid,
    output logic [W-1:0] mul_a,
    output logic [W-1:0] mul_b,
    input  logic         mul_res_valid,
    input  logic [W-1:0] mul_res,
    input  logic [2:0]   mul_flags,
    output logic [1:0]   resp_valid,
    output logic [W-1:0] resp_data,
    output logic [2:0]   resp_flags,
    input  logic         flush,
    output logic         flush_done,
    output logic         busy,
    output logic         err
);

    localparam int CW = $clog2(MUL_LAT + 1);
    localparam logic [CW-1:0] ONE = CW'(1);

    fsm_state_t    state_q;
    fsm_state_t    state_d;
    logic          ptr_q;
    logic [1:0]    grant;
    logic          gnt_id;
    logic          both_req;
    logic          only_req1;
    logic [CW-1:0] inflight_q;
    logic [CW-1:0] inflight_d;
    logic          last_valid;
    logic          last_id;
    logic          hit;
    logic          proto_err;
    logic          done_q;
    logic          err_q;
    logic [1:0]    rvalid_q;
    logic [W-1:0]  rdata_q;
    mul_flags_t    rflags_q;

    assign both_req  = &req_valid;
    assign only_req1 = (req_valid == 2'b10);

    // ptr_q names the requester that wins the next tie
    always_comb begin
        grant  = '0;
        gnt_id = 1'b0;
        if (state_q == ST_RUN && !flush) begin
            unique case (1'b1)
                both_req:  gnt_id = ptr_q;
                only_req1: gnt_id = 1'b1;
                default:   gnt_id = 1'b0;
            endcase
            if (|req_valid) begin
                grant = id_onehot(gnt_id);
            end
        end
    end

    assign req_ready = grant;
    assign mul_valid = |grant;
    assign mul_a     = !mul_valid ? '0 : (gnt_id ? req_a1 : req_a0);
    assign mul_b     = !mul_valid ? '0 : (gnt_id ? req_b1 : req_b0);

    fpu_mul_tag_pipe #(
        .MUL_LAT (MUL_LAT)
    ) u_tag_pipe (
        .CLK       (CLK),
        .RST       (RST),
        .in_valid  (mul_valid),
        .in_id     (gnt_id),
        .out_valid (last_valid),
        .out_id    (last_id)
    );

    assign hit       = last_valid & mul_res_valid;
    assign proto_err = last_valid ^ mul_res_valid;

    always_comb begin
        inflight_d = inflight_q;
        unique case ({mul_valid, last_valid})
            2'b10:   inflight_d = inflight_q + ONE;
            2'b01:   inflight_d = inflight_q - ONE;
            default: inflight_d = inflight_q;
        endcase
    end

    // a drain runs to completion even if flush drops midway
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_RUN: begin
                if (flush) state_d = ST_DRAIN;
            end
            ST_DRAIN: begin
                if (inflight_q == '0) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (!flush) state_d = ST_RUN;
            end
            default: state_d = ST_RUN;
        endcase
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_q    <= ST_RUN;
            ptr_q      <= 1'b0;
            inflight_q <= '0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            inflight_q <= inflight_d;
            done_q     <= (state_d == ST_DONE);
            if (mul_valid) begin
                ptr_q <= ~gnt_id;
            end
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            rvalid_q <= '0;
            rdata_q  <= '0;
            rflags_q <= '0;
            err_q    <= 1'b0;
        end else begin
            rvalid_q <= '0;
            if (hit) begin
                rvalid_q <= id_onehot(last_id);
                rdata_q  <= mul_res;
                rflags_q <= mul_flags_t'(mul_flags);
            end
            if (proto_err) begin
                err_q <= 1'b1;
            end
        end
    end

    assign resp_valid = rvalid_q;
    assign resp_data  = rdata_q;
    assign resp_flags = rflags_q;
    assign flush_done = done_q;
    assign busy       = (inflight_q != '0);
    assign err        = err_q;

endmodule

// File: tb/tb_fpu_mul_arbiter.sv
// Directed + randomized bench for fpu_mul_arbiter with a fixed-latency
// multiplier model and a cycle-indexed reference of expected responses.
module tb_fpu_mul_arbiter;

    localparam int LAT = 3;

    logic        CLK = 1'b0;
    logic        RST;
    logic [1:0]  req_valid;
    logic [1:0]  req_ready;
    logic [31:0] req_a0, req_b0, req_a1, req_b1;
    logic        mul_valid;
    logic [31:0] mul_a, mul_b;
    logic        mul_res_valid;
    logic [31:0] mul_res;
    logic [2:0]  mul_flags;
    logic [1:0]  resp_valid;
    logic [31:0] resp_data;
    logic [2:0]  resp_flags;
    logic        flush;
    logic        flush_done;
    logic        busy;
    logic        err;

    fpu_mul_arbiter #(.MUL_LAT(LAT), .W(32)) dut (
        .CLK           (CLK),
        .RST           (RST),
        .req_valid     (req_valid),
        .req_ready     (req_ready),
        .req_a0        (req_a0),
        .req_b0        (req_b0),
        .req_a1        (req_a1),
        .req_b1        (req_b1),
        .mul_valid     (mul_valid),
        .mul_a         (mul_a),
        .mul_b         (mul_b),
        .mul_res_valid (mul_res_valid),
        .mul_res       (mul_res),
        .mul_flags     (mul_flags),
        .resp_valid    (resp_valid),
        .resp_data     (resp_data),
        .resp_flags    (resp_flags),
        .flush         (flush),
        .flush_done    (flush_done),
        .busy          (busy),
        .err           (err)
    );

    always #5 CLK = ~CLK;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;

    // issues as the DUT sees them (cleared by reset) and as the
    // multiplier sees them (unaffected by reset), indexed by cycle
    logic        iv   [64];
    logic        iid  [64];
    logic [31:0] ires [64];
    logic [2:0]  iflg [64];
    logic        mv   [64];
    logic [31:0] mres [64];
    logic [2:0]  mflg [64];

    int          mode;
    logic        pref;
    logic [1:0]  e_rv;
    logic [31:0] e_rd;
    logic [2:0]  e_rf;
    logic        e_err;
    logic        inject;

    function automatic int idx(input int c);
        return c & 63;
    endfunction

    function automatic logic [31:0] fres(input logic [31:0] a, input logic [31:0] b);
        if (a == 32'h4000_0000 && b == 32'h4040_0000) return 32'h40C0_0000;
        return a ^ {b[15:0], b[31:16]};
    endfunction

    function automatic logic [2:0] fflg(input logic [31:0] a, input logic [31:0] b);
        if (a[30:0] == 31'd0 || b[30:0] == 31'd0) return 3'b001;
        return {a[31] & b[0], a[0] & b[31], 1'b0};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic step();
        logic [1:0]  g;
        logic        gid;
        logic        due;
        logic [31:0] ea;
        logic [31:0] eb;
        int          infl;
        int          di;
        di = idx(cyc - LAT);
        mul_res_valid = mv[di] | inject;
        mul_res       = mv[di] ? mres[di] : $urandom;
        mul_flags     = mv[di] ? mflg[di] : 3'($urandom);
        @(negedge CLK);
        g   = 2'b00;
        gid = 1'b0;
        if (RST && mode == 0 && !flush && req_valid != 2'b00) begin
            if (req_valid == 2'b11) gid = pref;
            else gid = req_valid[1];
            g[gid] = 1'b1;
        end
        ea = (g == 2'b00) ? 32'h0 : (gid ? req_a1 : req_a0);
        eb = (g == 2'b00) ? 32'h0 : (gid ? req_b1 : req_b0);
        infl = 0;
        for (int k = 1; k <= LAT; k++) begin
            if (iv[idx(cyc - k)]) infl++;
        end
        chk("req_ready", req_ready, g);
        chk("mul_valid", mul_valid, g != 2'b00);
        chk("mul_a", mul_a, ea);
        chk("mul_b", mul_b, eb);
        chk("busy", busy, infl != 0);
        chk("flush_done", flush_done, mode == 2);
        iv[idx(cyc)]   = (g != 2'b00);
        iid[idx(cyc)]  = gid;
        ires[idx(cyc)] = fres(ea, eb);
        iflg[idx(cyc)] = fflg(ea, eb);
        mv[idx(cyc)]   = (g != 2'b00);
        mres[idx(cyc)] = fres(ea, eb);
        mflg[idx(cyc)] = fflg(ea, eb);
        due = iv[di];
        if (!RST) begin
            e_rv = 2'b00; e_rd = '0; e_rf = '0; e_err = 1'b0;
            mode = 0; pref = 1'b0;
        end else begin
            e_rv = 2'b00;
            if (due && mul_res_valid) begin
                e_rv = iid[di] ? 2'b10 : 2'b01;
                e_rd = ires[di];
                e_rf = iflg[di];
            end
            if (due != mul_res_valid) e_err = 1'b1;
            if (g != 2'b00) pref = ~gid;
            case (mode)
                0: if (flush) mode = 1;
                1: if (infl == 0) mode = 2;
                default: if (!flush) mode = 0;
            endcase
        end
        @(posedge CLK);
        #1;
        cyc++;
        chk("resp_valid", resp_valid, e_rv);
        chk("resp_data", resp_data, e_rd);
        chk("resp_flags", resp_flags, e_rf);
        chk("err", err, e_err);
    endtask

    task automatic do_reset();
        RST = 1'b0;
        req_valid = 2'b00;
        flush = 1'b0;
        #1;
        chk("rst_resp_valid", resp_valid, 2'b00);
        chk("rst_resp_data", resp_data, 32'h0);
        chk("rst_resp_flags", resp_flags, 3'b000);
        chk("rst_flush_done", flush_done, 1'b0);
        chk("rst_err", err, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_mul_valid", mul_valid, 1'b0);
        for (int k = 0; k < 64; k++) iv[k] = 1'b0;
        e_rv = 2'b00; e_rd = '0; e_rf = '0; e_err = 1'b0;
        mode = 0; pref = 1'b0;
        step();
        RST = 1'b1;
    endtask

    task automatic rand_ops();
        req_a0 = $urandom; req_b0 = $urandom;
        req_a1 = $urandom; req_b1 = $urandom;
    endtask

    task automatic idle(input int n);
        req_valid = 2'b00;
        for (int k = 0; k < n; k++) begin
            rand_ops();
            step();
        end
    endtask

    initial begin
        RST = 1'b0; req_valid = 2'b00; flush = 1'b0; inject = 1'b0;
        mul_res_valid = 1'b0; mul_res = '0; mul_flags = '0;
        req_a0 = '0; req_b0 = '0; req_a1 = '0; req_b1 = '0;
        for (int k = 0; k < 64; k++) begin
            iv[k] = 1'b0; iid[k] = 1'b0; ires[k] = '0; iflg[k] = '0;
            mv[k] = 1'b0; mres[k] = '0; mflg[k] = '0;
        end
        mode = 0; pref = 1'b0;
        e_rv = 2'b00; e_rd = '0; e_rf = '0; e_err = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        do_reset();

        // single request: 2.0 * 3.0
        req_valid = 2'b01;
        req_a0 = 32'h4000_0000; req_b0 = 32'h4040_0000;
        step();
        idle(3);
        chk("single_valid", resp_valid, 2'b01);
        chk("single_data", resp_data, 32'h40C0_0000);
        idle(2);

        // contention for four cycles
        req_valid = 2'b11;
        for (int k = 0; k < 4; k++) begin
            rand_ops();
            step();
        end
        idle(5);

        // random traffic
        for (int k = 0; k < 40; k++) begin
            rand_ops();
            req_valid = 2'($urandom);
            step();
        end
        idle(4);

        // zero flag routed to requester 1
        req_valid = 2'b10;
        rand_ops();
        req_a1 = 32'h0;
        step();
        idle(3);
        chk("zero_valid", resp_valid, 2'b10);
        chk("zero_flags", resp_flags, 3'b001);
        idle(2);

        // flush after two issues, requests held throughout
        req_valid = 2'b01;
        rand_ops(); step();
        rand_ops(); step();
        flush = 1'b1;
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            step();
        end
        chk("flush_done_hi", flush_done, 1'b1);
        flush = 1'b0;
        rand_ops(); step();
        rand_ops(); step();
        idle(4);

        // flush dropped mid-drain still completes the drain
        req_valid = 2'b10;
        rand_ops(); step();
        flush = 1'b1;
        rand_ops(); step();
        flush = 1'b0;
        req_valid = 2'b11;
        for (int k = 0; k < 6; k++) begin
            rand_ops();
            step();
        end
        idle(4);

        // stray result with an empty pipe
        inject = 1'b1;
        step();
        inject = 1'b0;
        chk("inj_err", err, 1'b1);
        chk("inj_resp_valid", resp_valid, 2'b00);
        idle(2);
        chk("inj_err_sticky", err, 1'b1);

        // reset with two ops in flight, stale results follow
        #0 do_reset();
        req_valid = 2'b01;
        rand_ops(); step();
        rand_ops(); step();
        do_reset();
        idle(3);
        chk("stray_err", err, 1'b1);
        chk("stray_resp_valid", resp_valid, 2'b00);

        do_reset();
        idle(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
